// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, signed or unsigned
// operands, start/busy/done handshake with divide-by-zero and overflow flags.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovF
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] orig;
  logic             neg_q, neg_r, dz, ov;

  logic [WIDTH:0]   shifted, trial;
  logic             q_bit;
  logic [WIDTH-1:0] dvd_abs, dsr_abs, q_fix, r_fix;
  logic             last;
  logic             zero_div, ov_case;

  assign last     = (cnt == CW'(WIDTH - 1));
  assign zero_div = (divisor == '0);
  assign ov_case  = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

  // The remainder always fits WIDTH bits, so only the shifted value and the
  // trial difference need the extra bit; bit WIDTH of trial is the borrow.
  always_comb begin
    dvd_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    dsr_abs = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted = {pr, wd[WIDTH-1]};
    trial   = shifted - {1'b0, dsr};
    q_bit   = ~trial[WIDTH];
    q_fix   = neg_q ? -wd : wd;
    r_fix   = neg_r ? -pr : pr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = zero_div ? FIX : RUN;
      RUN:     if (last)  state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      pr          <= '0;
      wd          <= '0;
      dsr         <= '0;
      orig        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      ovF         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            orig  <= dividend;
            wd    <= dvd_abs;
            dsr   <= dsr_abs;
            neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_op && dividend[WIDTH-1];
            dz    <= zero_div;
            ov    <= ov_case;
            cnt   <= '0;
            pr    <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          pr  <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          wd  <= {wd[WIDTH-2:0], q_bit};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          quotient    <= dz ? '1   : q_fix;
          remainder   <= dz ? orig : r_fix;
          div_by_zero <= dz;
          ovF         <= ov;
        end
        default: ;
      endcase
    end
  end

endmodule
